mem_access: RTL and testbench

- MEM-stage load/store unit between the EX/MEM pipeline register and mem_wb.
- Passes ALU results straight through to the writeback path.
- For load/store ops, runs a request/acknowledge transaction on the data bus and holds the pipeline (stallreq) until the transaction completes.
- Extracts and extends load data (big-endian byte lanes) and produces mem_wd/mem_wreg/mem_wdata for mem_wb.

---
 rtl/mem_access_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_access.sv | 156 +++++++++++++++
 tb/tb_mem_access.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit: memory op codes,
// FSM states and the writeback constants.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8,
    MEM_LL   = 4'd9,
    MEM_SC   = 4'd10
  } memop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'd0;
  localparam logic        WriteDisable = 1'b0;

  function automatic logic is_load(input memop_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LL};
  endfunction

  function automatic logic is_store(input memop_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SC};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: byte enables and store replication on the
// way out, load extraction and sign/zero extension on the way back.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  memop_e      op,
  input  logic [1:0]  addr,
  input  logic [31:0] storedata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    sel   = 4'b0000;
    wdata = ZeroWord;
    case (op)
      MEM_SB: begin
        sel   = 4'b1000 >> addr;
        wdata = {4{storedata[7:0]}};
      end
      MEM_SH: begin
        sel   = addr[1] ? 4'b0011 : 4'b1100;
        wdata = {2{storedata[15:0]}};
      end
      MEM_SW, MEM_SC: begin
        sel   = 4'b1111;
        wdata = storedata;
      end
      MEM_LB, MEM_LBU: sel = 4'b1000 >> addr;
      MEM_LH, MEM_LHU: sel = addr[1] ? 4'b0011 : 4'b1100;
      MEM_LW, MEM_LL:  sel = 4'b1111;
      default: ;
    endcase
  end

  // Lane 00 is the most significant byte of the bus word.
  always_comb begin
    case (addr)
      2'd0:    rbyte = rdata[31:24];
      2'd1:    rbyte = rdata[23:16];
      2'd2:    rbyte = rdata[15:8];
      default: rbyte = rdata[7:0];
    endcase
    rhalf = addr[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    case (op)
      MEM_LB:         load_data = {{24{rbyte[7]}}, rbyte};
      MEM_LBU:        load_data = {24'h000000, rbyte};
      MEM_LH:         load_data = {{16{rhalf[15]}}, rhalf};
      MEM_LHU:        load_data = {16'h0000, rhalf};
      MEM_LW, MEM_LL: load_data = rdata;
      default:        load_data = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: ALU pass-through plus a req/ack data-bus
// transaction that stalls the pipeline. Optional LL/SC support under LLSC_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [3:0]        ex_memop,
  input  logic [ADDR_W-1:0] ex_memaddr,
  input  logic [DATA_W-1:0] ex_storedata,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stallreq,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_e            state, state_next;
  memop_e            op;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        sel;
  logic [DATA_W-1:0] wdata, load_data;
  logic              half_op, word_op, sc_ok, sc_fail, need_bus;

  // Unknown opcodes (and LL/SC when the feature is absent) collapse to NONE.
  always_comb begin
    case (ex_memop)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: op = memop_e'(ex_memop);
`ifdef LLSC_EN
      4'd9, 4'd10: op = memop_e'(ex_memop);
`endif
      default: op = MEM_NONE;
    endcase
  end

`ifdef LLSC_EN
  logic llbit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llbit <= 1'b0;
    end else if (state == ST_DONE) begin
      if (op == MEM_LL) llbit <= 1'b1;
      else if (op == MEM_SC) llbit <= 1'b0;
    end
  end

  assign sc_ok = llbit;
`else
  assign sc_ok = 1'b0;
`endif

  assign half_op  = op inside {MEM_LH, MEM_LHU, MEM_SH};
  assign word_op  = op inside {MEM_LW, MEM_SW, MEM_LL, MEM_SC};
  assign misalign = (half_op & ex_memaddr[0]) | (word_op & (ex_memaddr[1:0] != 2'b00));
  assign sc_fail  = (op == MEM_SC) & ~sc_ok;
  assign need_bus = (is_load(op) | is_store(op)) & ~misalign & ~sc_fail;

  mem_lane_align u_align (
    .op        (op),
    .addr      (ex_memaddr[1:0]),
    .storedata (ex_storedata),
    .rdata     (rdata_q),
    .sel       (sel),
    .wdata     (wdata),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    stallreq   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (need_bus) begin
          stallreq   = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stallreq = 1'b1;
        if (bus_ack) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus signals are registered at issue and held until the acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= 4'b0000;
      bus_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (need_bus) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store(op);
            bus_addr  <= {ex_memaddr[ADDR_W-1:2], 2'b00};
            bus_sel   <= sel;
            bus_wdata <= wdata;
          end
        end
        ST_WAIT: begin
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_sel <= 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end

  // SC reports its outcome while llbit still holds its pre-DONE value.
  always_comb begin
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    if (misalign) begin
      mem_wreg = WriteDisable;
    end else if (op == MEM_SC) begin
      mem_wdata = {{(DATA_W-1){1'b0}}, sc_ok};
    end else if (is_load(op)) begin
      mem_wdata = load_data;
    end else if (is_store(op)) begin
      mem_wreg  = WriteDisable;
      mem_wdata = ZeroWord;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a byte-addressed
// memory model; LL/SC expectations follow the LLSC_EN macro.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_memop;
  logic [31:0] ex_memaddr;
  logic [31:0] ex_storedata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:1023];
  bit llbit_m = 1'b0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_memop     (ex_memop),
    .ex_memaddr   (ex_memaddr),
    .ex_storedata (ex_storedata),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .stallreq     (stallreq),
    .misalign     (misalign),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_sel      (bus_sel),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int b;
    b = int'(a[9:0]) & ~3;
    return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
  endfunction

  // Presents one op right after an edge and follows it until the pipeline advances.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                               input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                               input int delay);
    int size, off;
    bit load, store, sgn, sc, ll, misal, bus;
    logic [3:0]  esel;
    logic [31:0] ewdata, eval;
    size = 0; load = 0; store = 0; sgn = 0; sc = 0; ll = 0;
    case (op)
      4'd1: begin load = 1; size = 1; sgn = 1; end
      4'd2: begin load = 1; size = 1; end
      4'd3: begin load = 1; size = 2; sgn = 1; end
      4'd4: begin load = 1; size = 2; end
      4'd5: begin load = 1; size = 4; end
      4'd6: begin store = 1; size = 1; end
      4'd7: begin store = 1; size = 2; end
      4'd8: begin store = 1; size = 4; end
`ifdef LLSC_EN
      4'd9:  begin load = 1; size = 4; ll = 1; end
      4'd10: begin store = 1; size = 4; sc = 1; end
`endif
      default: ;
    endcase
    off   = int'(addr[1:0]);
    misal = (size == 2 && addr[0]) || (size == 4 && off != 0);
    bus   = (load || store) && !misal && !(sc && !llbit_m);

    ex_memop = op; ex_memaddr = addr; ex_storedata = sd;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    bus_ack = 1'b0;
    #1;
    checkOutput("misalign", 32'(misalign), 32'(misal));
    checkOutput("mem_wd", 32'(mem_wd), 32'(wd));

    if (!bus) begin
      checkOutput("stall_nobus", 32'(stallreq), 32'd0);
      if (misal) begin
        checkOutput("wreg_misal", 32'(mem_wreg), 32'd0);
      end else if (sc) begin
        checkOutput("sc_fail_data", mem_wdata, 32'd0);
        checkOutput("sc_fail_wreg", 32'(mem_wreg), 32'(wreg));
      end else begin
        checkOutput("pass_wdata", mem_wdata, wdata);
        checkOutput("pass_wreg", 32'(mem_wreg), 32'(wreg));
      end
      tick();
      checkOutput("nobus_req", 32'(bus_req), 32'd0);
    end else begin
      checkOutput("stall_issue", 32'(stallreq), 32'd1);
      checkOutput("req_before", 32'(bus_req), 32'd0);
      tick();
      esel = 4'b0000;
      for (int i = 0; i < size; i++) esel[3-(off+i)] = 1'b1;
      ewdata = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
      checkOutput("bus_req", 32'(bus_req), 32'd1);
      checkOutput("bus_we", 32'(bus_we), 32'(store));
      checkOutput("bus_addr", bus_addr, {addr[31:2], 2'b00});
      checkOutput("bus_sel", 32'(bus_sel), 32'(esel));
      if (store) checkOutput("bus_wdata", bus_wdata, ewdata);
      for (int k = 0; k < delay; k++) begin
        checkOutput("stall_wait", 32'(stallreq), 32'd1);
        tick();
        checkOutput("req_held", 32'(bus_req), 32'd1);
      end
      bus_rdata = word_at(addr);
      bus_ack   = 1'b1;
      #1;
      checkOutput("stall_ack", 32'(stallreq), 32'd1);
      tick();
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      #1;
      checkOutput("stall_done", 32'(stallreq), 32'd0);
      checkOutput("req_done", 32'(bus_req), 32'd0);
      checkOutput("sel_done", 32'(bus_sel), 32'd0);
      if (load) begin
        eval = 32'd0;
        for (int i = 0; i < size; i++) eval = (eval << 8) | 32'(mem[int'(addr[9:0]) + i]);
        if (sgn && eval[8*size-1]) eval = eval | (32'hFFFF_FFFF << (8*size));
        checkOutput("load_data", mem_wdata, eval);
        checkOutput("load_wreg", 32'(mem_wreg), 32'(wreg));
        if (ll) llbit_m = 1'b1;
      end else begin
        if (sc) begin
          checkOutput("sc_ok_data", mem_wdata, 32'd1);
          checkOutput("sc_ok_wreg", 32'(mem_wreg), 32'(wreg));
          llbit_m = 1'b0;
        end else begin
          checkOutput("store_wreg", 32'(mem_wreg), 32'd0);
        end
        for (int i = 0; i < size; i++) mem[int'(addr[9:0]) + i] = 8'(sd >> (8*(size-1-i)));
      end
      tick();
      checkOutput("no_reissue", 32'(bus_req), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[256] = 8'h11; mem[257] = 8'h80; mem[258] = 8'h22; mem[259] = 8'h33;

    rst = 1'b0; ex_memop = 4'd0; ex_memaddr = 32'd0; ex_storedata = 32'd0;
    ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    #12;
    checkOutput("rst_req", 32'(bus_req), 32'd0);
    checkOutput("rst_we", 32'(bus_we), 32'd0);
    checkOutput("rst_addr", bus_addr, 32'd0);
    checkOutput("rst_sel", 32'(bus_sel), 32'd0);
    checkOutput("rst_wdata", bus_wdata, 32'd0);
    checkOutput("rst_stall", 32'(stallreq), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    tick();
    rst = 1'b1;

    $display("[TB] directed sequence");
    applyStimulus(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0);
    applyStimulus(4'd1, 32'h101, 32'h0, 5'd7, 1'b1, 32'hDEAD, 2);
    applyStimulus(4'd7, 32'h202, 32'hAAAA_BEEF, 5'd3, 1'b1, 32'h0, 0);
    applyStimulus(4'd5, 32'h103, 32'h0, 5'd9, 1'b1, 32'h55, 0);

    // Abort a LW while it is waiting for the bus.
    ex_memop = 4'd5; ex_memaddr = 32'h300; ex_wd = 5'd4; ex_wreg = 1'b1;
    tick();
    checkOutput("abort_req_pre", 32'(bus_req), 32'd1);
    #2;
    rst = 1'b0;
    ex_memop = 4'd0; ex_memaddr = 32'd0; ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0;
    #1;
    checkOutput("abort_req", 32'(bus_req), 32'd0);
    checkOutput("abort_stall", 32'(stallreq), 32'd0);
    llbit_m = 1'b0;
    tick();
    rst = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    #1;
    checkOutput("stray_ack_stall", 32'(stallreq), 32'd0);
    tick();
    bus_ack = 1'b0;
    checkOutput("stray_ack_req", 32'(bus_req), 32'd0);
    checkOutput("stray_ack_data", mem_wdata, 32'd0);
    applyStimulus(4'd5, 32'h300, 32'h0, 5'd4, 1'b1, 32'h0, 1);

    applyStimulus(4'd9, 32'h40, 32'h0, 5'd2, 1'b1, 32'h0, 0);
    applyStimulus(4'd10, 32'h40, 32'h1357_9BDF, 5'd2, 1'b1, 32'h0, 1);
    applyStimulus(4'd10, 32'h40, 32'h2468_ACE0, 5'd2, 1'b1, 32'h0, 0);
    applyStimulus(4'd5, 32'h40, 32'h0, 5'd6, 1'b1, 32'h0, 0);

    $display("[TB] random sequence");
    for (int n = 0; n < 80; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), 32'($urandom_range(0, 1023)), $urandom,
                    5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
